// File: rtl/conv_pe_q_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_q_if
// Purpose  : Beat input and result output bundle for conv_pe_q.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_pe_q_if #(
    parameter int CH_PAR = 8,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8
);
    logic                      valid_in;
    logic                      in_ready;
    logic                      last_channel;
    logic                      kernel_1x1;
    logic [9*CH_PAR*PIX_W-1:0] pixels;
    logic [9*CH_PAR*WGT_W-1:0] weights;
    logic signed [ACC_W-1:0]   bias;
    logic [4:0]                shift;
    logic                      leaky_en;
    logic signed [ACC_W-1:0]   out_raw;
    logic signed [OUT_W-1:0]   out_q;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output valid_in, last_channel, kernel_1x1, pixels, weights,
               bias, shift, leaky_en, out_ready,
        input  in_ready, out_raw, out_q, out_valid
    );

    modport slave (
        input  valid_in, last_channel, kernel_1x1, pixels, weights,
               bias, shift, leaky_en, out_ready,
        output in_ready, out_raw, out_q, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/conv_pe_q.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_q
// Purpose  : 3x3 / 1x1 multi-channel conv PE with accumulation, bias, leaky
//            ReLU and round/shift/saturate requantisation to OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pe_q #(
    parameter int CH_PAR = 8,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    conv_pe_q_if.slave bus
);
    localparam int c_N  = 9 * CH_PAR;
    localparam int c_PW = PIX_W + WGT_W + 1;
    localparam int c_TW = c_PW + $clog2(CH_PAR);
    localparam int c_SW = c_TW + 4;
    localparam int c_RW = ACC_W + 1;
    localparam logic signed [c_RW-1:0] c_QMAX = c_RW'(2**(OUT_W-1) - 1);
    localparam logic signed [c_RW-1:0] c_QMIN = c_RW'(-(2**(OUT_W-1)));

    logic w_adv;

    logic [c_N*PIX_W-1:0]    r0_pix;
    logic [c_N*WGT_W-1:0]    r0_wgt;
    logic                    r0_vld, r0_last, r0_k1, r0_leaky;
    logic signed [ACC_W-1:0] r0_bias;
    logic [4:0]              r0_shift;

    logic signed [c_PW-1:0]  w_prod  [c_N];
    logic signed [c_PW-1:0]  r1_prod [c_N];
    logic                    r1_vld, r1_last, r1_leaky;
    logic signed [ACC_W-1:0] r1_bias;
    logic [4:0]              r1_shift;

    logic signed [c_TW-1:0]  w_tap  [9];
    logic signed [c_TW-1:0]  r2_tap [9];
    logic                    r2_vld, r2_last, r2_leaky;
    logic signed [ACC_W-1:0] r2_bias;
    logic [4:0]              r2_shift;

    logic signed [c_SW-1:0]  w_csum;
    logic signed [c_SW-1:0]  r3_csum;
    logic                    r3_vld, r3_last, r3_leaky;
    logic signed [ACC_W-1:0] r3_bias;
    logic [4:0]              r3_shift;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r4_sum;
    logic                    r4_vld, r4_leaky;
    logic [4:0]              r4_shift;

    logic signed [ACC_W-1:0] w_y;
    logic signed [c_RW-1:0]  w_rnd, w_r;
    logic signed [OUT_W-1:0] w_q;

    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_raw;
    logic signed [OUT_W-1:0] r_out_q;

    // A held, unaccepted result freezes every stage including the accumulator.
    assign w_adv         = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_raw   = r_out_raw;
    assign bus.out_q     = r_out_q;

    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            if (r0_k1 && ((i / CH_PAR) != 4)) begin
                w_prod[i] = '0;
            end else begin
                w_prod[i] = $signed({{(c_PW-PIX_W){1'b0}}, r0_pix[i*PIX_W +: PIX_W]})
                          * $signed({{(c_PW-WGT_W){r0_wgt[i*WGT_W+WGT_W-1]}},
                                     r0_wgt[i*WGT_W +: WGT_W]});
            end
        end
    end

    always_comb begin
        for (int t = 0; t < 9; t++) begin
            w_tap[t] = '0;
            for (int c = 0; c < CH_PAR; c++) begin
                w_tap[t] = w_tap[t] + c_TW'(r1_prod[t*CH_PAR+c]);
            end
        end
    end

    always_comb begin
        w_csum = '0;
        for (int t = 0; t < 9; t++) begin
            w_csum = w_csum + c_SW'(r2_tap[t]);
        end
    end

    // Round half up by adding 2^(shift-1) before the arithmetic shift.
    always_comb begin
        w_y   = (r4_leaky && r4_sum[ACC_W-1]) ? (r4_sum >>> 3) : r4_sum;
        w_rnd = (r4_shift != 5'd0) ? (c_RW'(1) << (r4_shift - 5'd1)) : '0;
        w_r   = (c_RW'(w_y) + w_rnd) >>> r4_shift;
        if (w_r > c_QMAX) begin
            w_q = c_QMAX[OUT_W-1:0];
        end else if (w_r < c_QMIN) begin
            w_q = c_QMIN[OUT_W-1:0];
        end else begin
            w_q = w_r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_vld      <= 1'b0;
            r1_vld      <= 1'b0;
            r2_vld      <= 1'b0;
            r3_vld      <= 1'b0;
            r4_vld      <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_raw   <= '0;
            r_out_q     <= '0;
        end else if (w_adv) begin
            r0_vld      <= bus.valid_in;
            r1_vld      <= r0_vld;
            r2_vld      <= r1_vld;
            r3_vld      <= r2_vld;
            r4_vld      <= r3_vld && r3_last;
            if (r3_vld) begin
                r_acc <= r3_last ? '0 : (r_acc + ACC_W'(r3_csum));
            end
            r_out_valid <= r4_vld;
            if (r4_vld) begin
                r_out_raw <= r4_sum;
                r_out_q   <= w_q;
            end
        end
    end

    // Datapath and side-band registers carry no reset; the valid pipe qualifies them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r0_pix   <= bus.pixels;
            r0_wgt   <= bus.weights;
            r0_last  <= bus.last_channel;
            r0_k1    <= bus.kernel_1x1;
            r0_leaky <= bus.leaky_en;
            r0_bias  <= bus.bias;
            r0_shift <= bus.shift;

            r1_prod  <= w_prod;
            r1_last  <= r0_last;
            r1_leaky <= r0_leaky;
            r1_bias  <= r0_bias;
            r1_shift <= r0_shift;

            r2_tap   <= w_tap;
            r2_last  <= r1_last;
            r2_leaky <= r1_leaky;
            r2_bias  <= r1_bias;
            r2_shift <= r1_shift;

            r3_csum  <= w_csum;
            r3_last  <= r2_last;
            r3_leaky <= r2_leaky;
            r3_bias  <= r2_bias;
            r3_shift <= r2_shift;

            r4_sum   <= r_acc + ACC_W'(r3_csum) + r3_bias;
            r4_leaky <= r3_leaky;
            r4_shift <= r3_shift;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_pe_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pe_q
// Purpose  : Scoreboard bench for conv_pe_q with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pe_q;
    localparam int CH_PAR = 8;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int NB     = 9 * CH_PAR;

    typedef struct { int raw; int q; } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    conv_pe_q_if #(.CH_PAR(CH_PAR), .PIX_W(PIX_W), .WGT_W(WGT_W),
                   .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    conv_pe_q #(.CH_PAR(CH_PAR), .PIX_W(PIX_W), .WGT_W(WGT_W),
                .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bp_mode  = 0;
    int   model_acc = 0;
    int   last_acc_cyc = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int beat_sum(input logic [NB*8-1:0] p, input logic [NB*8-1:0] w,
                                    input bit k1);
        int s;
        s = 0;
        for (int t = 0; t < 9; t++) begin
            if (!(k1 && t != 4)) begin
                for (int c = 0; c < CH_PAR; c++) begin
                    logic [7:0] pb;
                    logic [7:0] wb;
                    pb = p[(t*CH_PAR+c)*8 +: 8];
                    wb = w[(t*CH_PAR+c)*8 +: 8];
                    s += int'(pb) * int'($signed(wb));
                end
            end
        end
        return s;
    endfunction

    function automatic int quant(input int sum, input bit leaky, input int sh);
        longint y, r;
        y = sum;
        if (leaky && y < 0) y = fdiv(y, 8);
        if (sh != 0) y = y + (longint'(1) << (sh - 1));
        r = fdiv(y, longint'(1) << sh);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Downstream ready pattern: 0 always ready, 1 random, 2 held low.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    logic        prev_hold = 1'b0;
    logic [31:0] prev_raw  = '0;
    logic [7:0]  prev_q    = '0;

    always @(negedge clk) begin
        exp_t e;
        chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (prev_hold && rst_n) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_raw", $signed(bus.out_raw), $signed(prev_raw));
            chk("hold_q", $signed(bus.out_q), $signed(prev_q));
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_raw", $signed(bus.out_raw), e.raw);
                chk("out_q", $signed(bus.out_q), e.q);
            end
        end
        prev_hold = rst_n && bus.out_valid && !bus.out_ready;
        prev_raw  = bus.out_raw;
        prev_q    = bus.out_q;
    end

    task automatic send_beat(input logic [NB*8-1:0] p, input logic [NB*8-1:0] w,
                             input bit k1, input bit last, input int bias, input int sh,
                             input bit leaky, input bit use_lit, input int lit_raw,
                             input int lit_q);
        int   n;
        int   bs;
        int   sum;
        exp_t e;
        bus.pixels       = p;
        bus.weights      = w;
        bus.kernel_1x1   = k1;
        bus.last_channel = last;
        bus.bias         = bias;
        bus.shift        = 5'(sh);
        bus.leaky_en     = leaky;
        bus.valid_in     = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        last_acc_cyc     = cyc;
        bus.valid_in     = 1'b0;
        bus.last_channel = 1'b0;
        bs = beat_sum(p, w, k1);
        if (last) begin
            sum   = model_acc + bs + bias;
            e.raw = use_lit ? lit_raw : sum;
            e.q   = use_lit ? lit_q : quant(sum, leaky, sh);
            sb.push_back(e);
            model_acc = 0;
        end else begin
            model_acc += bs;
        end
    endtask

    task automatic idle_cycle();
        bus.valid_in     = 1'b0;
        bus.last_channel = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        bus.last_channel = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB*8-1:0] fill(input logic [7:0] v);
        logic [NB*8-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [NB*8-1:0] rnd_bus();
        logic [NB*8-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    initial begin
        logic [NB*8-1:0] ones, zeros;
        int n;
        ones  = fill(8'd1);
        zeros = fill(8'd0);
        bus.valid_in = 1'b0; bus.last_channel = 1'b0; bus.kernel_1x1 = 1'b0;
        bus.pixels = '0; bus.weights = '0; bus.bias = '0; bus.shift = '0; bus.leaky_en = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_raw", $signed(bus.out_raw), 0);
        chk("rst_out_q", $signed(bus.out_q), 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat group with latency measurement
        send_beat(ones, ones, 0, 1, 0, 0, 0, 1, 72, 72);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - last_acc_cyc, 5);
        drain();

        // Three beats, leaky, shift 16
        for (int b = 0; b < 3; b++)
            send_beat(fill(8'd255), fill(8'h80), 0, (b == 2), 1000, 16, 1, 1, -7049240, -13);
        drain();

        send_beat(fill(8'd2), fill(8'd3), 1, 1, 0, 0, 0, 1, 48, 48);
        send_beat(fill(8'd2), fill(8'd3), 0, 1, 0, 0, 0, 1, 432, 127);
        drain();

        send_beat(zeros, ones, 0, 1, 1000, 0, 0, 1, 1000, 127);
        send_beat(zeros, ones, 0, 1, -1000, 0, 0, 1, -1000, -128);
        send_beat(zeros, ones, 0, 1, -1000, 0, 1, 1, -1000, -125);
        drain();

        // Backpressure with two back-to-back groups
        bp_mode = 2;
        @(posedge clk); #1;
        send_beat(rnd_bus(), rnd_bus(), 0, 1, int'($urandom_range(0, 4000)) - 2000, 4, 1, 0, 0, 0);
        send_beat(rnd_bus(), rnd_bus(), 0, 1, int'($urandom_range(0, 4000)) - 2000, 8, 0, 0, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bp_mode = 0;
        drain();

        // Reset in the middle of a group
        send_beat(ones, ones, 0, 0, 0, 0, 0, 0, 0, 0);
        send_beat(ones, ones, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_raw", $signed(bus.out_raw), 0);
        chk("arst_in_ready", bus.in_ready, 1);
        model_acc = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(ones, ones, 0, 1, 0, 0, 0, 1, 72, 72);
        drain();

        // Randomised groups under random backpressure
        bp_mode = 1;
        for (int g = 0; g < 40; g++) begin
            int  nb;
            int  bias;
            int  sh;
            bit  lk;
            nb   = $urandom_range(1, 4);
            bias = int'($urandom_range(0, 200000)) - 100000;
            sh   = $urandom_range(0, 20);
            lk   = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_beat(rnd_bus(), rnd_bus(), 1'($urandom_range(0, 1)), (b == nb - 1),
                          bias, sh, lk, 0, 0, 0);
            end
        end
        bp_mode = 0;
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
